// File: rtl/stepper_pkg.sv
// Shared definitions for the stepper move sequencer: motor command codes,
// controller state encoding and default widths.
package stepper_pkg;

   localparam int CNT_W_DEF      = 16;
   localparam int DIV_W_DEF      = 20;
   localparam int SETTLE_CYC_DEF = 1000;
   localparam int POS_W_DEF      = 32;

   typedef enum logic [1:0] {
      MOT_HOLD = 2'b00,
      MOT_FWD  = 2'b01,
      MOT_REV  = 2'b10
   } mot_code_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_RUN    = 2'b01,
      ST_SETTLE = 2'b10
   } state_t;

   // Step code for a latched direction (0 = forward, 1 = reverse); 11 is never produced.
   function automatic logic [1:0] step_code(input logic dir);
      return dir ? MOT_REV : MOT_FWD;
   endfunction

endpackage

// File: rtl/stepper_rate_divider.sv
// Loadable period counter. Counts 0..period-1 while enabled and raises tc
// combinationally on the last count; load restarts the count at 0 and wins
// over a coincident wrap. Used both as the step-rate divider and the settle timer.
module stepper_rate_divider #(
   parameter int W = 20
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         load,
   input  logic         en,
   input  logic [W-1:0] period,
   output logic         tc
);

   localparam logic [W-1:0] ONE = W'(1);

   logic [W-1:0] count_reg;

   assign tc = en && (count_reg == (period - ONE));

   // Count register: cleared by reset or load, wraps to 0 on terminal count.
   always_ff @(posedge clk) begin
      if (!rstn || load) begin
         count_reg <= '0;
      end else if (en) begin
         count_reg <= tc ? '0 : (count_reg + ONE);
      end
   end

endmodule

// File: rtl/stepper_move_controller.sv
// Move sequencer in front of the stepper motor core. Takes move commands over
// a valid/ready handshake, issues one step code per period on mot_cmd, then
// holds for a settle interval and pulses done (with aborted when cut short).
// Optional feature macro: STEPPER_POS_TRACK_EN adds the signed absolute
// position counter (pos) and its clear input (pos_clr).
module stepper_move_controller
   import stepper_pkg::*;
#(
   parameter int CNT_W      = CNT_W_DEF,
   parameter int DIV_W      = DIV_W_DEF,
   parameter int SETTLE_CYC = SETTLE_CYC_DEF
`ifdef STEPPER_POS_TRACK_EN
   , parameter int POS_W    = POS_W_DEF
`endif
) (
   input  logic              system1000,
   input  logic              system1000_rstn,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_dir,
   input  logic [CNT_W-1:0]  cmd_steps,
   input  logic [DIV_W-1:0]  cmd_period,
   input  logic              abort,
   output logic [1:0]        mot_cmd,
   output logic              busy,
   output logic              done,
   output logic              aborted,
   output logic [CNT_W-1:0]  steps_left
`ifdef STEPPER_POS_TRACK_EN
   , output logic signed [POS_W-1:0] pos,
   input  logic              pos_clr
`endif
);

   // One divider serves both phases, so it must be wide enough for either the
   // step period or SETTLE_CYC+1 (settle hold cycles plus the terminal count).
   localparam int SET_W = $clog2(SETTLE_CYC + 2);
   localparam int DW    = (DIV_W > SET_W) ? DIV_W : SET_W;

   localparam logic [DW-1:0]    SETTLE_PERIOD = DW'(SETTLE_CYC + 1);
   localparam logic [DW-1:0]    DIV_ONE       = DW'(1);
   localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);

   state_t           state_reg;
   logic [1:0]       mot_cmd_reg;
   logic             cmd_ready_reg;
   logic             busy_reg;
   logic             done_reg;
   logic             aborted_reg;
   logic [CNT_W-1:0] steps_left_reg;
   logic             dir_reg;
   logic [DW-1:0]    period_reg;
   logic             abort_flag_reg;

   logic accept;
   logic start_run;
   logic step_fire;
   logic last_step;
   logic run_exit;
   logic div_load;
   logic div_en;
   logic div_tc;

   assign accept    = cmd_valid && cmd_ready_reg;
   assign start_run = (state_reg == ST_IDLE) && accept && (cmd_steps != '0);
   assign step_fire = (state_reg == ST_RUN) && div_tc;
   assign last_step = step_fire && (steps_left_reg == CNT_ONE);
   // Abort coinciding with a step edge still lets that step out; leaving RUN
   // happens on the last step or on abort, whichever comes first.
   assign run_exit  = (state_reg == ST_RUN) && (last_step || abort);
   assign div_load  = start_run || run_exit;
   assign div_en    = (state_reg != ST_IDLE);

   stepper_rate_divider #(
      .W (DW)
   ) u_divider (
      .clk    (system1000),
      .rstn   (system1000_rstn),
      .load   (div_load),
      .en     (div_en),
      .period (period_reg),
      .tc     (div_tc)
   );

   // Move FSM with all handshake, status and motor outputs registered.
   always_ff @(posedge system1000) begin
      if (!system1000_rstn) begin
         state_reg      <= ST_IDLE;
         mot_cmd_reg    <= MOT_HOLD;
         cmd_ready_reg  <= 1'b1;
         busy_reg       <= 1'b0;
         done_reg       <= 1'b0;
         aborted_reg    <= 1'b0;
         steps_left_reg <= '0;
         dir_reg        <= 1'b0;
         period_reg     <= DIV_ONE;
         abort_flag_reg <= 1'b0;
      end else begin
         mot_cmd_reg <= MOT_HOLD;
         done_reg    <= 1'b0;
         aborted_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (accept) begin
                  if (cmd_steps == '0) begin
                     done_reg <= 1'b1;
                  end else begin
                     state_reg      <= ST_RUN;
                     dir_reg        <= cmd_dir;
                     steps_left_reg <= cmd_steps;
                     period_reg     <= (cmd_period == '0) ? DIV_ONE : DW'(cmd_period);
                     cmd_ready_reg  <= 1'b0;
                     busy_reg       <= 1'b1;
                     abort_flag_reg <= 1'b0;
                  end
               end
            end
            ST_RUN: begin
               if (step_fire) begin
                  mot_cmd_reg    <= step_code(dir_reg);
                  steps_left_reg <= steps_left_reg - CNT_ONE;
               end
               if (run_exit) begin
                  state_reg      <= ST_SETTLE;
                  period_reg     <= SETTLE_PERIOD;
                  abort_flag_reg <= !last_step;
               end
            end
            ST_SETTLE: begin
               if (div_tc) begin
                  state_reg     <= ST_IDLE;
                  done_reg      <= 1'b1;
                  aborted_reg   <= abort_flag_reg;
                  cmd_ready_reg <= 1'b1;
                  busy_reg      <= 1'b0;
               end
            end
            default: begin
               state_reg     <= ST_IDLE;
               cmd_ready_reg <= 1'b1;
               busy_reg      <= 1'b0;
            end
         endcase
      end
   end

   assign mot_cmd    = mot_cmd_reg;
   assign cmd_ready  = cmd_ready_reg;
   assign busy       = busy_reg;
   assign done       = done_reg;
   assign aborted    = aborted_reg;
   assign steps_left = steps_left_reg;

`ifdef STEPPER_POS_TRACK_EN
   localparam logic signed [POS_W-1:0] POS_ONE = POS_W'(1);

   logic signed [POS_W-1:0] pos_reg;

   // Absolute position follows every issued step code; a clear beats a coincident step.
   always_ff @(posedge system1000) begin
      if (!system1000_rstn) begin
         pos_reg <= '0;
      end else if (pos_clr) begin
         pos_reg <= '0;
      end else if (step_fire) begin
         pos_reg <= dir_reg ? (pos_reg - POS_ONE) : (pos_reg + POS_ONE);
      end
   end

   assign pos = pos_reg;
`endif

endmodule

// File: tb/tb_stepper_move_controller.sv
// Directed, table-driven bench for stepper_move_controller with SETTLE_CYC=5.
// Cycle offsets are counted from the accept edge (offset 0 = cycle after it).
module tb_stepper_move_controller;

   localparam int CNT_W      = 16;
   localparam int DIV_W      = 20;
   localparam int SETTLE_CYC = 5;
   localparam int MAX_OFF    = 400;

   logic             clk        = 1'b0;
   logic             rstn       = 1'b0;
   logic             cmd_valid  = 1'b0;
   logic             cmd_dir    = 1'b0;
   logic [CNT_W-1:0] cmd_steps  = '0;
   logic [DIV_W-1:0] cmd_period = '0;
   logic             abort      = 1'b0;
   logic             cmd_ready;
   logic [1:0]       mot_cmd;
   logic             busy;
   logic             done;
   logic             aborted;
   logic [CNT_W-1:0] steps_left;
`ifdef STEPPER_POS_TRACK_EN
   localparam int POS_W = 8;
   logic signed [POS_W-1:0] pos;
   logic                    pos_clr = 1'b0;
`endif

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      logic dir;
      int   steps;
      int   period;
      int   exp_per;    // expected spacing of step codes in cycles
      int   abort_at;   // offset of first edge with abort high (-1 none)
      int   abort_len;  // number of edges abort stays high
      int   clr_at;     // offset of edge with pos_clr high (-1 none)
      bit   hold_valid; // keep a second command on cmd_* during the move
      int   exp_steps;
      int   exp_left;
      int   exp_done;   // offset at which done is visible
      bit   exp_ab;
   } vec_t;

   vec_t vecs[10];

   stepper_move_controller #(
      .CNT_W      (CNT_W),
      .DIV_W      (DIV_W),
      .SETTLE_CYC (SETTLE_CYC)
`ifdef STEPPER_POS_TRACK_EN
      , .POS_W    (POS_W)
`endif
   ) dut (
      .system1000      (clk),
      .system1000_rstn (rstn),
      .cmd_valid       (cmd_valid),
      .cmd_ready       (cmd_ready),
      .cmd_dir         (cmd_dir),
      .cmd_steps       (cmd_steps),
      .cmd_period      (cmd_period),
      .abort           (abort),
      .mot_cmd         (mot_cmd),
      .busy            (busy),
      .done            (done),
      .aborted         (aborted),
      .steps_left      (steps_left)
`ifdef STEPPER_POS_TRACK_EN
      , .pos           (pos),
      .pos_clr         (pos_clr)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic signed [63:0] act,
                        input logic signed [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Issue one command and watch it to completion, comparing against v.
   task automatic run_move(input vec_t v, input string tag);
      int         steps_seen;
      int         bad_off;
      int         bad_code;
      int         ready_bad;
      int         busy_seen;
      int         done_off;
      int         left_at_done;
      int         ab_at_done;
      int         rdy_at_done;
      logic [1:0] exp_code;
      exp_code     = v.dir ? 2'b10 : 2'b01;
      steps_seen   = 0;
      bad_off      = 0;
      bad_code     = 0;
      ready_bad    = 0;
      busy_seen    = 0;
      done_off     = -1;
      left_at_done = -1;
      ab_at_done   = -1;
      rdy_at_done  = -1;
      cmd_dir    = v.dir;
      cmd_steps  = CNT_W'(v.steps);
      cmd_period = DIV_W'(v.period);
      cmd_valid  = 1'b1;
      abort      = (v.abort_at == 0) && (v.abort_len > 0);
`ifdef STEPPER_POS_TRACK_EN
      pos_clr    = (v.clr_at == 0);
`endif
      @(posedge clk); #1;
      if (v.hold_valid) begin
         cmd_dir    = ~v.dir;
         cmd_steps  = CNT_W'(7);
         cmd_period = DIV_W'(1);
      end else begin
         cmd_valid = 1'b0;
      end
      for (int off = 0; off <= MAX_OFF; off++) begin
         if (off > 0) begin
            @(posedge clk); #1;
         end
         if (mot_cmd !== 2'b00) begin
            steps_seen++;
            if (mot_cmd !== exp_code) bad_code++;
            if (off != steps_seen * v.exp_per) bad_off++;
         end
         if (busy === 1'b1) busy_seen = 1;
         if (done === 1'b1) begin
            done_off     = off;
            left_at_done = int'(steps_left);
            ab_at_done   = int'(aborted);
            rdy_at_done  = int'(cmd_ready);
            cmd_valid    = 1'b0;
            break;
         end
         if (cmd_ready !== 1'b0) ready_bad++;
         abort = (off + 1 >= v.abort_at) && (off + 1 < v.abort_at + v.abort_len);
`ifdef STEPPER_POS_TRACK_EN
         pos_clr = (off + 1 == v.clr_at);
`endif
      end
      cmd_valid = 1'b0;
      abort     = 1'b0;
`ifdef STEPPER_POS_TRACK_EN
      pos_clr   = 1'b0;
`endif
      $display("move %-12s dir=%0d steps=%0d period=%0d abort_at=%0d -> issued=%0d left=%0d done_at=%0d aborted=%0d",
               tag, v.dir, v.steps, v.period, v.abort_at, steps_seen, left_at_done, done_off, ab_at_done);
      check({tag, " step_count"}, 64'(steps_seen), 64'(v.exp_steps));
      check({tag, " step_timing"}, 64'(bad_off), 64'(0));
      check({tag, " step_code"}, 64'(bad_code), 64'(0));
      check({tag, " done_offset"}, 64'(done_off), 64'(v.exp_done));
      check({tag, " steps_left"}, 64'(left_at_done), 64'(v.exp_left));
      check({tag, " aborted"}, 64'(ab_at_done), 64'(v.exp_ab));
      check({tag, " ready_at_done"}, 64'(rdy_at_done), 64'(1));
      check({tag, " ready_low_run"}, 64'(ready_bad), 64'(0));
      check({tag, " busy_seen"}, 64'(busy_seen), 64'(v.steps != 0));
      @(posedge clk); #1;
      check({tag, " done_width"}, 64'(done), 64'(0));
      check({tag, " busy_after"}, 64'(busy), 64'(0));
   endtask

   initial begin : main
      int   bad;
      vec_t v;

      //          dir   N    P  per  ab_at len clr hold  steps left done ab
      vecs[0] = '{1'b0, 3,   4, 4,   -1,  0,  -1, 1'b0, 3,    0,   18,  1'b0};
      vecs[1] = '{1'b1, 5,   0, 1,   -1,  0,  -1, 1'b0, 5,    0,   11,  1'b0};
      vecs[2] = '{1'b0, 10,  8, 8,   33,  1,  -1, 1'b0, 4,    6,   39,  1'b1};
      vecs[3] = '{1'b0, 10,  8, 8,   80,  1,  -1, 1'b0, 10,   0,   86,  1'b0};
      vecs[4] = '{1'b1, 2,   3, 3,   3,   1,  -1, 1'b0, 1,    1,   9,   1'b1};
      vecs[5] = '{1'b0, 1,   1, 1,   -1,  0,  -1, 1'b1, 1,    0,   7,   1'b0};
      vecs[6] = '{1'b0, 0,   5, 5,   -1,  0,  -1, 1'b0, 0,    0,   0,   1'b0};
      vecs[7] = '{1'b1, 4,   5, 5,   1,   1,  -1, 1'b0, 0,    4,   7,   1'b1};
      vecs[8] = '{1'b0, 2,   2, 2,   6,   3,  -1, 1'b0, 2,    0,   10,  1'b0};
      vecs[9] = '{1'b1, 3,   2, 2,   -1,  0,  -1, 1'b1, 3,    0,   12,  1'b0};

      // Reset held for two edges.
      rstn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst mot_cmd", 64'(mot_cmd), 64'(0));
      check("rst cmd_ready", 64'(cmd_ready), 64'(1));
      check("rst busy", 64'(busy), 64'(0));
      check("rst done", 64'(done), 64'(0));
      check("rst aborted", 64'(aborted), 64'(0));
      check("rst steps_left", 64'(steps_left), 64'(0));
`ifdef STEPPER_POS_TRACK_EN
      check("rst pos", 64'(pos), 64'(0));
`endif
      rstn = 1'b1;
      @(posedge clk); #1;

      // Abort while idle has no effect.
      bad = 0;
      abort = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         if (mot_cmd !== 2'b00 || busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1) bad++;
      end
      abort = 1'b0;
      $display("idle abort: 3 cycles, disturbed=%0d", bad);
      check("idle_abort", 64'(bad), 64'(0));

      for (int i = 0; i < 10; i++) begin
         run_move(vecs[i], $sformatf("vec%0d", i));
      end

      // Reset in the middle of a P=1 move.
      cmd_dir = 1'b0; cmd_steps = CNT_W'(8); cmd_period = DIV_W'(1); cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      check("midrst step_before", 64'(mot_cmd), 64'(1));
      rstn = 1'b0;
      @(posedge clk); #1;
      check("midrst mot_cmd", 64'(mot_cmd), 64'(0));
      check("midrst cmd_ready", 64'(cmd_ready), 64'(1));
      check("midrst busy", 64'(busy), 64'(0));
      check("midrst steps_left", 64'(steps_left), 64'(0));
      check("midrst done", 64'(done), 64'(0));
      rstn = 1'b1;
      bad = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (done !== 1'b0 || mot_cmd !== 2'b00 || busy !== 1'b0) bad++;
      end
      $display("reset mid-move: 20 quiet cycles checked, disturbed=%0d", bad);
      check("midrst quiet", 64'(bad), 64'(0));

`ifdef STEPPER_POS_TRACK_EN
      check("pos after midrst", 64'($signed(pos)), 64'(0));
      v = '{1'b0, 5, 1, 1, -1, 0, -1, 1'b0, 5, 0, 11, 1'b0};
      run_move(v, "pos_fwd5");
      check("pos +5", 64'($signed(pos)), 64'(5));
      v = '{1'b1, 7, 1, 1, -1, 0, -1, 1'b0, 7, 0, 13, 1'b0};
      run_move(v, "pos_rev7");
      check("pos -2", 64'($signed(pos)), -64'sd2);
      pos_clr = 1'b1;
      @(posedge clk); #1;
      pos_clr = 1'b0;
      $display("pos clear: pos=%0d", pos);
      check("pos clr", 64'($signed(pos)), 64'(0));
      v = '{1'b0, 127, 1, 1, -1, 0, -1, 1'b0, 127, 0, 133, 1'b0};
      run_move(v, "pos_fwd127");
      check("pos 127", 64'($signed(pos)), 64'(127));
      v = '{1'b0, 1, 1, 1, -1, 0, -1, 1'b0, 1, 0, 7, 1'b0};
      run_move(v, "pos_wrap");
      check("pos wrap", 64'($signed(pos)), -64'sd128);
      v = '{1'b0, 3, 4, 4, -1, 0, 4, 1'b0, 3, 0, 18, 1'b0};
      run_move(v, "pos_clr_step");
      check("pos clr_vs_step", 64'($signed(pos)), 64'(2));
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
